fetch_sequencer: RTL and testbench

- Instruction-fetch sequencer that drives the Execute stage's instruction stream.
- Holds the program counter, reads instruction memory through a req/ack handshake, and hands fetched words to decode through a valid/ready handshake.
- Tracks the PCs of in-flight instructions in a small FIFO, so a taken branch (Execute's global_disable pulse with delta_instruction) redirects fetch to branch_pc + delta and flushes everything younger.

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over imem req/ack, presents words to decode
// over valid/ready and tracks in-flight PCs so a taken branch can redirect fetch and flush.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  input  logic              instr_ready,
  input  logic              exec_step,
  input  logic              global_disable,
  input  logic [31:0]       delta_instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic              push;
  logic              pop;
  logic              flush;
  logic [31:0]       target_full;
  logic [ADDR_W-1:0] target;
  logic              unused_target_bits;

  // Target is formed at 32 bits and truncated, so negative deltas wrap modulo 2^ADDR_W.
  always_comb begin
    push        = (state == HOLD) && instr_valid && instr_ready;
    pop         = exec_step && (count != '0);
    flush       = global_disable && (count != '0);
    target_full = 32'(fifo_mem[head]) + delta_instruction;
    target      = target_full[ADDR_W-1:0];
    count_n     = count + CW'(push) - CW'(pop);
  end

  assign unused_target_bits = ^target_full;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (run && (count < CW'(DEPTH))) state_n = REQ;
      REQ:  if (imem_ack) state_n = HOLD;
      HOLD: if (push) state_n = (run && (count_n < CW'(DEPTH))) ? REQ : IDLE;
      DROP: if (imem_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A redirect with a request still outstanding must wait out the stale ack in DROP.
    if (flush && (state != DROP)) begin
      state_n = ((state == REQ) && !imem_ack) ? DROP : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= ADDR_W'(RESET_PC);
      imem_addr   <= ADDR_W'(RESET_PC);
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      halted      <= 1'b1;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      state       <= state_n;
      imem_req    <= (state_n == REQ) || (state_n == DROP);
      instr_valid <= (state_n == HOLD);
      halted      <= (state_n == IDLE) && !run;
      if ((state_n == REQ) && (state != REQ)) imem_addr <= pc;
      if ((state == REQ) && imem_ack && !flush) instr <= imem_rdata;
      if (flush) begin
        pc    <= target;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if ((state == REQ) && imem_ack) pc <= pc + ADDR_W'(1);
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= count_n;
      end
    end
  end

  // The word in HOLD was fetched from pc-1, since pc advanced on its ack.
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[tail] <= pc - ADDR_W'(1);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner sequences and a
// randomized run scored against a queue-based model of the in-flight PCs.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        exec_step;
  logic        global_disable;
  logic [31:0] delta_instruction;
  logic [15:0] pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .exec_step(exec_step), .global_disable(global_disable), .delta_instruction(delta_instruction),
    .pc(pc), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        run, ack;
    logic [31:0] rdata;
    logic        ready, exec, gd;
    logic [31:0] delta;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [31:0] ins;
    logic [15:0] pcv;
    logic        hlt;
    logic        chk_ins;
  } vec_t;

  function automatic vec_t mk(logic r, logic a, logic [31:0] rd, logic rdy, logic ex, logic g,
                              logic [31:0] d, logic q, logic [15:0] ad, logic v,
                              logic [31:0] i, logic [15:0] p, logic h, logic ci);
    vec_t t;
    t.run = r; t.ack = a; t.rdata = rd; t.ready = rdy; t.exec = ex; t.gd = g; t.delta = d;
    t.req = q; t.addr = ad; t.valid = v; t.ins = i; t.pcv = p; t.hlt = h; t.chk_ins = ci;
    return t;
  endfunction

  function automatic logic [31:0] word_at(logic [15:0] a);
    return {a, a ^ 16'hA5A5};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    exec_step = 0; global_disable = 0; delta_instruction = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wait_req(input int max_cycles);
    for (int i = 0; i < max_cycles && !imem_req; i++) tick();
    chk("wait_req", imem_req, 1);
  endtask

  task automatic fetch_accept(input logic [31:0] w);
    wait_req(8);
    imem_ack = 1; imem_rdata = w;
    tick();
    imem_ack = 0;
    chk("fa_valid", instr_valid, 1);
    chk("fa_instr", instr, w);
    instr_ready = 1;
    tick();
    instr_ready = 0;
  endtask

  vec_t tv[$];

  initial begin
    logic [15:0] q[$];
    logic [15:0] nf, fetched, prev_addr, tgt;
    logic        prev_req, accept, took, flush, popq, dropped;
    int          accepts, d;

    rst_n = 0;
    clear_inputs();

    //            run ack rdata         rdy ex gd delta          req addr v instr         pc  h  ci
    tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,            1, 0,  0, 0,            0,  0, 1));
    tv.push_back(mk(1, 1, 32'hCAFE,     0, 0, 0, 0,            0, 0,  1, 32'hCAFE,     1,  0, 1));
    tv.push_back(mk(1, 0, 0,            1, 0, 0, 0,            1, 1,  0, 32'hCAFE,     1,  0, 1));
    tv.push_back(mk(1, 1, 32'hDEAD,     0, 1, 0, 0,            0, 1,  1, 32'hDEAD,     2,  0, 1));
    tv.push_back(mk(1, 0, 0,            1, 0, 0, 0,            1, 2,  0, 32'hDEAD,     2,  0, 1));
    tv.push_back(mk(1, 1, 32'hBEEF,     0, 1, 0, 0,            0, 2,  1, 32'hBEEF,     3,  0, 1));
    tv.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 2,  0, 32'hBEEF,     3,  1, 1));
    tv.push_back(mk(0, 0, 0,            0, 1, 0, 0,            0, 2,  0, 32'hBEEF,     3,  1, 1));
    tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,            1, 3,  0, 32'hBEEF,     3,  0, 1));
    tv.push_back(mk(1, 1, 32'h1234,     0, 0, 0, 0,            0, 3,  1, 32'h1234,     4,  0, 1));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1, 0, 0,          0, 0, 0, 0,            0, 3,  1, 32'h1234,     4,  0, 1));
    tv.push_back(mk(1, 0, 0,            1, 0, 0, 0,            1, 4,  0, 32'h1234,     4,  0, 1));
    tv.push_back(mk(1, 1, 32'h5555,     0, 0, 0, 0,            0, 4,  1, 32'h5555,     5,  0, 1));
    tv.push_back(mk(1, 0, 0,            0, 0, 1, 32'd10,       0, 4,  0, 0,            13, 0, 0));
    tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,            1, 13, 0, 0,            13, 0, 0));
    tv.push_back(mk(1, 1, 32'h77,       0, 0, 0, 0,            0, 13, 1, 32'h77,       14, 0, 1));
    tv.push_back(mk(0, 0, 0,            1, 0, 0, 0,            0, 13, 0, 32'h77,       14, 1, 1));

    // Reset values
    repeat (2) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 1);
    chk("rst_instr", instr, 0);
    rst_n = 1;
    tick();

    foreach (tv[i]) begin
      run = tv[i].run; imem_ack = tv[i].ack; imem_rdata = tv[i].rdata;
      instr_ready = tv[i].ready; exec_step = tv[i].exec;
      global_disable = tv[i].gd; delta_instruction = tv[i].delta;
      tick();
      chk($sformatf("tv%0d_req", i), imem_req, tv[i].req);
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), instr_valid, tv[i].valid);
      if (tv[i].chk_ins) chk($sformatf("tv%0d_instr", i), instr, tv[i].ins);
      chk($sformatf("tv%0d_pc", i), pc, tv[i].pcv);
      chk($sformatf("tv%0d_halted", i), halted, tv[i].hlt);
    end
    clear_inputs();

    // FIFO full: four accepts without retirement stall fetch until one exec_step
    do_reset();
    run = 1;
    for (int i = 0; i < 4; i++) fetch_accept(32'h100 + i);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_noreq", imem_req, 0);
    end
    exec_step = 1;
    tick();
    exec_step = 0;
    wait_req(3);
    chk("full_resume_addr", imem_addr, 4);
    fetch_accept(32'h104);
    exec_step = 1;
    repeat (4) tick();
    exec_step = 0;
    run = 0;
    fetch_accept(32'h105);
    global_disable = 1; delta_instruction = 32'hFFFF_FFFE;
    tick();
    global_disable = 0;
    chk("neg_pc", pc, 3);
    chk("neg_valid", instr_valid, 0);
    run = 1;
    wait_req(3);
    chk("neg_addr", imem_addr, 3);

    // Redirect while a request is outstanding: the late word is dropped
    imem_ack = 1; imem_rdata = 32'h333;
    tick();
    imem_ack = 0;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    chk("drop_pre_addr", imem_addr, 4);
    global_disable = 1; delta_instruction = 32'd5;
    tick();
    global_disable = 0;
    chk("drop_req", imem_req, 1);
    chk("drop_stale_addr", imem_addr, 4);
    chk("drop_pc", pc, 8);
    chk("drop_valid", instr_valid, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drop_hold_req", imem_req, 1);
      chk("drop_hold_addr", imem_addr, 4);
    end
    imem_ack = 1; imem_rdata = 32'hBAD;
    tick();
    imem_ack = 0;
    chk("drop_done_req", imem_req, 0);
    chk("drop_done_valid", instr_valid, 0);
    chk("drop_done_pc", pc, 8);
    wait_req(3);
    chk("drop_next_addr", imem_addr, 8);
    imem_ack = 1; imem_rdata = 32'h600D;
    tick();
    imem_ack = 0;
    chk("drop_next_valid", instr_valid, 1);
    chk("drop_next_instr", instr, 32'h600D);
    chk("drop_next_pc", pc, 9);
    instr_ready = 1;
    tick();
    instr_ready = 0;

    // Asynchronous reset during a request; a late ack is ignored
    wait_req(3);
    #2;
    rst_n = 0;
    #1;
    chk("areset_req", imem_req, 0);
    chk("areset_valid", instr_valid, 0);
    chk("areset_pc", pc, 0);
    chk("areset_halted", halted, 1);
    chk("areset_instr", instr, 0);
    imem_ack = 1; run = 0;
    tick();
    rst_n = 1;
    tick();
    chk("late_ack_req", imem_req, 0);
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_pc", pc, 0);
    imem_ack = 0; run = 1;
    wait_req(3);
    chk("restart_addr", imem_addr, 0);

    // Randomized run against the in-flight PC queue model
    do_reset();
    nf = 0; fetched = 0; dropped = 0; accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(9) != 0);
      imem_ack = imem_req && ($urandom_range(1) == 0);
      imem_rdata = word_at(imem_addr);
      instr_ready = ($urandom_range(2) != 0);
      exec_step = ($urandom_range(2) == 0);
      global_disable = ($urandom_range(19) == 0);
      d = int'($urandom_range(40)) - 20;
      delta_instruction = d;
      accept = instr_valid && instr_ready;
      took = imem_req && imem_ack;
      flush = global_disable && (q.size() != 0);
      popq = exec_step && (q.size() != 0);
      if (accept) chk("rnd_instr", instr, word_at(fetched));
      prev_req = imem_req;
      prev_addr = imem_addr;
      tick();
      if (flush) begin
        tgt = q[0] + delta_instruction[15:0];
        q.delete();
        nf = tgt;
        if (prev_req && !took) dropped = 1;
        chk("rnd_flush_valid", instr_valid, 0);
      end else begin
        if (popq) void'(q.pop_front());
        if (accept) begin
          q.push_back(fetched);
          accepts++;
        end
        if (took) begin
          if (dropped) dropped = 0;
          else begin
            fetched = prev_addr;
            nf = nf + 16'd1;
          end
        end
      end
      chk("rnd_pc", pc, nf);
      chk("rnd_excl", imem_req && instr_valid, 0);
      if (imem_req && !prev_req) begin
        chk("rnd_req_addr", imem_addr, nf);
        chk("rnd_req_room", q.size() < 4, 1);
      end
      if (prev_req && imem_req && !took) chk("rnd_addr_stable", imem_addr, prev_addr);
    end
    chk("rnd_progress", accepts >= 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
